// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter and sequencer in front of the
//               64-byte doubleword data memory. One request in flight at a
//               time (IDLE -> ACCESS -> RESP), out-of-range accesses are
//               rejected without strobing the memory, one-cycle response.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MEM_BYTES = 64,
    parameter int ACC_BYTES = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [63:0] req0_addr,
    input  logic [63:0] req0_wdata,
    output logic        rsp0_valid,
    output logic [63:0] rsp0_rdata,
    output logic        rsp0_err,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [63:0] req1_addr,
    input  logic [63:0] req1_wdata,
    output logic        rsp1_valid,
    output logic [63:0] rsp1_rdata,
    output logic        rsp1_err,

    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [63:0] Read_Data
);

    // Highest start address whose whole doubleword still fits in memory.
    localparam logic [63:0] c_LAST_ADDR = 64'(MEM_BYTES - ACC_BYTES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_id;
    logic        r_write;
    logic        r_err;
    logic        r_rsp0_valid;
    logic        r_rsp1_valid;
    logic [63:0] r_rdata_q;
    logic        r_rsp_err;

    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic        w_sel_write;
    logic [63:0] w_sel_addr;
    logic [63:0] w_sel_wdata;
    logic        w_err;

    // Combinational round-robin grant: a lone requester wins, on contention
    // the port that was not served last wins. Held off while in reset so a
    // requester never sees a handshake that is then discarded.
    assign w_idle   = (r_state == S_IDLE) && !reset;
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);
    assign w_accept = w_grant0 || w_grant1;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign w_sel_write = w_grant1 ? req1_write : req0_write;
    assign w_sel_addr  = w_grant1 ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant1 ? req1_wdata : req0_wdata;

    // Unsigned compare, so huge addresses (top bit set) are rejected too.
    assign w_err = (w_sel_addr > c_LAST_ADDR);

    // Response data/err are forced to zero on the port not being answered.
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_rdata = r_rsp0_valid ? r_rdata_q : 64'd0;
    assign rsp1_rdata = r_rsp1_valid ? r_rdata_q : 64'd0;
    assign rsp0_err   = r_rsp0_valid && r_rsp_err;
    assign rsp1_err   = r_rsp1_valid && r_rsp_err;

    // Request sequencer: latch winner, strobe memory for one cycle, respond.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rdata_q    <= 64'd0;
            r_rsp_err    <= 1'b0;
            Mem_Addr     <= 64'd0;
            Write_Data   <= 64'd0;
            MemWrite     <= 1'b0;
            MemRead      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id         <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_write      <= w_sel_write;
                        r_err        <= w_err;
                        Mem_Addr     <= w_sel_addr;
                        Write_Data   <= w_sel_wdata;
                        MemWrite     <= w_sel_write && !w_err;
                        MemRead      <= !w_sel_write && !w_err;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Memory write/read completes at this edge.
                    r_rdata_q    <= (!r_write && !r_err) ? Read_Data : 64'd0;
                    r_rsp_err    <= r_err;
                    r_rsp0_valid <= !r_id;
                    r_rsp1_valid <= r_id;
                    Mem_Addr     <= 64'd0;
                    Write_Data   <= 64'd0;
                    MemWrite     <= 1'b0;
                    MemRead      <= 1'b0;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_rdata_q    <= 64'd0;
                    r_rsp_err    <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a
//               behavioural 64-byte little-endian data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_write;
    logic [63:0] req0_addr, req0_wdata;
    logic        rsp0_valid, rsp0_err;
    logic [63:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_write;
    logic [63:0] req1_addr, req1_wdata;
    logic        rsp1_valid, rsp1_err;
    logic [63:0] rsp1_rdata;
    logic [63:0] Mem_Addr, Write_Data, Read_Data;
    logic        MemWrite, MemRead;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem  [64];
    logic [7:0] snap [64];

    dmem_arbiter #(.MEM_BYTES(64), .ACC_BYTES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .Mem_Addr   (Mem_Addr),
        .Write_Data (Write_Data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Read_Data  (Read_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational little-endian read, write on posedge.
    always_comb begin
        Read_Data = 64'd0;
        for (int k = 0; k < 8; k++)
            Read_Data[8*k +: 8] = mem[6'(Mem_Addr[5:0] + 6'(k))];
    end

    always @(posedge clk) begin
        if (MemWrite)
            for (int k = 0; k < 8; k++)
                mem[6'(Mem_Addr[5:0] + 6'(k))] <= Write_Data[8*k +: 8];
    end

    // Cycle-by-cycle invariants on the response and memory interfaces.
    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if (MemRead && MemWrite) begin
                n_fail++; $display("FAIL mem_excl: MemRead=%0b MemWrite=%0b, required not both 1", MemRead, MemWrite);
            end
            if (!rsp0_valid && (rsp0_rdata !== 64'd0 || rsp0_err !== 1'b0)) begin
                n_fail++; $display("FAIL rsp0_idle_zero: rdata=%h err=%0b, required 0", rsp0_rdata, rsp0_err);
            end
            if (!rsp1_valid && (rsp1_rdata !== 64'd0 || rsp1_err !== 1'b0)) begin
                n_fail++; $display("FAIL rsp1_idle_zero: rdata=%h err=%0b, required 0", rsp1_rdata, rsp1_err);
            end
            if (rsp0_valid && rsp1_valid) begin
                n_fail++; $display("FAIL rsp_both: both rsp valid, required at most one");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Issues one request, waits (bounded) for grant and response, and reports
    // what was observed: wait cycles before grant, memory strobe cycles, rsp.
    task automatic issue(input bit p, input logic w, input logic [63:0] a,
                         input logic [63:0] d, output logic [63:0] rd,
                         output logic er, output bit ok, output int wait_cyc,
                         output int rd_cyc, output int wr_cyc);
        bit granted;
        granted = 0; ok = 0; rd = '0; er = 1'b0;
        wait_cyc = 0; rd_cyc = 0; wr_cyc = 0;
        if (p == 1'b0) begin
            req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d;
        end
        #1;
        for (int i = 0; i < 20; i++) begin
            if ((p == 1'b0 && req0_ready) || (p == 1'b1 && req1_ready)) begin
                granted = 1;
                break;
            end
            wait_cyc++;
            tick();
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (granted) begin
            for (int i = 0; i < 10; i++) begin
                rd_cyc += int'(MemRead);
                wr_cyc += int'(MemWrite);
                if (p == 1'b0 && rsp0_valid) begin
                    rd = rsp0_rdata; er = rsp0_err; ok = 1; break;
                end
                if (p == 1'b1 && rsp1_valid) begin
                    rd = rsp1_rdata; er = rsp1_err; ok = 1; break;
                end
                tick();
            end
            tick();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: r0=%0b r1=%0b, required 0", req0_ready, req1_ready);
        end
        n_checks++;
        if (MemRead !== 1'b0 || MemWrite !== 1'b0 || Mem_Addr !== 64'd0 || Write_Data !== 64'd0) begin
            n_fail++; $display("FAIL reset_mem: rd=%0b wr=%0b addr=%h wd=%h, required 0", MemRead, MemWrite, Mem_Addr, Write_Data);
        end
        n_checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp: v0=%0b v1=%0b, required 0", rsp0_valid, rsp1_valid);
        end
    endtask

    task automatic test_read();
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd8; req0_wdata = 64'd0;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL read_ready: r0=%0b r1=%0b, required 1/0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        n_checks++;
        if (MemRead !== 1'b1 || MemWrite !== 1'b0 || Mem_Addr !== 64'd8) begin
            n_fail++; $display("FAIL read_access: rd=%0b wr=%0b addr=%h, required 1/0/8", MemRead, MemWrite, Mem_Addr);
        end
        tick();
        n_checks++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 64'h0F0E0D0C0B0A0908 || rsp0_err !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++; $display("FAIL read_rsp: v0=%0b rdata=%h err=%0b v1=%0b, required 1/0f0e0d0c0b0a0908/0/0",
                               rsp0_valid, rsp0_rdata, rsp0_err, rsp1_valid);
        end
        n_checks++;
        if (MemRead !== 1'b0 || Mem_Addr !== 64'd0) begin
            n_fail++; $display("FAIL read_mem_clear: rd=%0b addr=%h, required 0", MemRead, Mem_Addr);
        end
        tick();
        n_checks++;
        if (rsp0_valid !== 1'b0) begin
            n_fail++; $display("FAIL read_rsp_oneshot: v0=%0b, required 0", rsp0_valid);
        end
    endtask

    task automatic test_store_load();
        logic [63:0] rd; logic er; bit ok; int wc, rc, wrc;
        issue(1'b1, 1'b1, 64'd16, 64'h1122334455667788, rd, er, ok, wc, rc, wrc);
        n_checks++;
        if (!ok || rd !== 64'd0 || er !== 1'b0 || wrc != 1 || rc != 0) begin
            n_fail++; $display("FAIL store16: ok=%0b rdata=%h err=%0b wr_cyc=%0d rd_cyc=%0d, required 1/0/0/1/0", ok, rd, er, wrc, rc);
        end
        issue(1'b1, 1'b0, 64'd16, 64'd0, rd, er, ok, wc, rc, wrc);
        n_checks++;
        if (!ok || rd !== 64'h1122334455667788 || er !== 1'b0 || rc != 1 || wrc != 0) begin
            n_fail++; $display("FAIL load16: ok=%0b rdata=%h err=%0b rd_cyc=%0d, required 1/1122334455667788/0/1", ok, rd, er, rc);
        end
    endtask

    task automatic test_contention();
        int g [4]; int gc [4]; int ng; logic [63:0] d0, d1; bit got0, got1;
        ng = 0; got0 = 0; got1 = 0; d0 = '0; d1 = '0;
        apply_reset();
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd0;  req0_wdata = 64'd0;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 64'd32; req1_wdata = 64'd0;
        #1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (req0_ready && ng < 4) begin g[ng] = 0; gc[ng] = cyc; ng++; end
            if (req1_ready && ng < 4) begin g[ng] = 1; gc[ng] = cyc; ng++; end
            if (rsp0_valid && !got0) begin d0 = rsp0_rdata; got0 = 1; end
            if (rsp1_valid && !got1) begin d1 = rsp1_rdata; got1 = 1; end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (ng != 4) begin
            n_fail++; $display("FAIL cont_count: grants=%0d, required 4", ng);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (g[k] != (k % 2) || gc[k] != 3 * k) begin
                    n_fail++; $display("FAIL cont_grant%0d: port=%0d cycle=%0d, required port=%0d cycle=%0d", k, g[k], gc[k], k % 2, 3 * k);
                end
            end
        end
        n_checks++;
        if (!got0 || d0 !== 64'h000000000000000A) begin
            n_fail++; $display("FAIL cont_rsp0: got=%0b rdata=%h, required 000000000000000a", got0, d0);
        end
        n_checks++;
        if (!got1 || d1 !== 64'h0706050403020100) begin
            n_fail++; $display("FAIL cont_rsp1: got=%0b rdata=%h, required 0706050403020100", got1, d1);
        end
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd; logic er; bit ok; int wc, rc, wrc; bit diff;
        issue(1'b0, 1'b0, 64'd57, 64'd0, rd, er, ok, wc, rc, wrc);
        n_checks++;
        if (!ok || er !== 1'b1 || rd !== 64'd0 || rc != 0 || wrc != 0) begin
            n_fail++; $display("FAIL oor_load57: ok=%0b err=%0b rdata=%h strobes=%0d/%0d, required 1/1/0/0/0", ok, er, rd, rc, wrc);
        end
        snap = mem;
        issue(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD_BEEF_CAFE_F00D, rd, er, ok, wc, rc, wrc);
        n_checks++;
        if (!ok || er !== 1'b1 || rd !== 64'd0 || rc != 0 || wrc != 0) begin
            n_fail++; $display("FAIL oor_store_high: ok=%0b err=%0b rdata=%h strobes=%0d/%0d, required 1/1/0/0/0", ok, er, rd, rc, wrc);
        end
        diff = 0;
        for (int k = 0; k < 64; k++) if (mem[k] !== snap[k]) diff = 1;
        n_checks++;
        if (diff) begin
            n_fail++; $display("FAIL oor_mem_unchanged: memory modified=%0b, required 0", diff);
        end
        issue(1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd0, rd, er, ok, wc, rc, wrc);
        n_checks++;
        if (!ok || er !== 1'b1 || rc != 0) begin
            n_fail++; $display("FAIL oor_load_2p63: ok=%0b err=%0b rd_cyc=%0d, required 1/1/0", ok, er, rc);
        end
        issue(1'b0, 1'b0, 64'd56, 64'd0, rd, er, ok, wc, rc, wrc);
        n_checks++;
        if (!ok || er !== 1'b0 || rd !== 64'h3F3E3D3C3B3A3938) begin
            n_fail++; $display("FAIL load56: ok=%0b err=%0b rdata=%h, required 1/0/3f3e3d3c3b3a3938", ok, er, rd);
        end
        issue(1'b1, 1'b0, 64'd3, 64'd0, rd, er, ok, wc, rc, wrc);
        n_checks++;
        if (!ok || er !== 1'b0 || rd !== 64'h0A09080000000000) begin
            n_fail++; $display("FAIL load3_unaligned: ok=%0b err=%0b rdata=%h, required 1/0/0a09080000000000", ok, er, rd);
        end
    endtask

    task automatic test_reset_midflight();
        logic [63:0] rd; logic er; bit ok; int wc, rc, wrc; bit granted;
        granted = 0;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd8; req0_wdata = 64'd0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (req0_ready) begin granted = 1; break; end
            tick();
        end
        tick();
        req0_valid = 1'b0;
        n_checks++;
        if (!granted || MemRead !== 1'b1) begin
            n_fail++; $display("FAIL mid_access: granted=%0b MemRead=%0b, required 1/1", granted, MemRead);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (rsp0_valid !== 1'b0 || MemRead !== 1'b0 || Mem_Addr !== 64'd0 || rsp0_rdata !== 64'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs: v0=%0b rd=%0b addr=%h rdata=%h, required 0", rsp0_valid, MemRead, Mem_Addr, rsp0_rdata);
        end
        tick();
        n_checks++;
        if (rsp0_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_no_rsp: v0=%0b, required 0", rsp0_valid);
        end
        issue(1'b1, 1'b0, 64'd8, 64'd0, rd, er, ok, wc, rc, wrc);
        n_checks++;
        if (!ok || wc != 0 || rd !== 64'h0F0E0D0C0B0A0908 || er !== 1'b0) begin
            n_fail++; $display("FAIL mid_next_p1: ok=%0b wait=%0d rdata=%h err=%0b, required 1/0/0f0e0d0c0b0a0908/0", ok, wc, rd, er);
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 8'(k);
        for (int k = 0; k < 8; k++) mem[k] = 8'h00;
        mem[0] = 8'h0A;
        for (int k = 0; k < 8; k++) mem[32 + k] = 8'(k);

        reset = 1'b1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;

        test_reset();
        test_read();
        test_store_load();
        test_contention();
        test_out_of_range();
        test_reset_midflight();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
